// File: rtl/monitor_pkg.sv
// ---------------------------------------------------------------------------
// monitor_pkg
// Shared types and constants for the store run monitor.
//   state_e        : run-monitor state (RUN / HALTED / TIMEOUT)
//   trace_entry_t  : one captured store {addr, data}
//   DEFAULT_*      : default halt address and cycle budget
//   sat_inc()      : 32-bit increment that sticks at all-ones
// ---------------------------------------------------------------------------
package monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_HALT_ADDR  = 32'h0000_0064;
    localparam int          DEFAULT_MAX_CYCLES = 500;
    localparam logic [31:0] COUNT_MAX          = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    // Counters saturate rather than wrap so a long run can never look short.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == COUNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Generic synchronous show-ahead FIFO. The head entry is presented
// combinationally while the FIFO is non-empty, and reads as zero when empty.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push_i/push_data_i: write request and data
//   pop_i             : read request (ignored while empty)
//   head_o            : head entry (zero when empty)
//   full_o, empty_o   : occupancy flags
// A push while full only lands when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bits means full.
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_d = do_push ? wr_q + PTR_ONE : wr_q;
    assign rd_d = do_pop  ? rd_q + PTR_ONE : rd_q;

    assign head_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are meaningful and an empty FIFO masks the head to zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/store_monitor.sv
// ---------------------------------------------------------------------------
// store_monitor
// Watches the data-memory port of the pipeline, records every store into a
// show-ahead trace FIFO, counts run cycles and stores, and ends the run on a
// store to HALT_ADDR (done) or when the cycle budget is used up (timeout).
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   MemWrite, DataAdr, WriteData : store strobe / address / data from top
//   rd_en                        : pop request for the trace FIFO
//   rd_valid, rd_addr, rd_data   : head entry of the trace FIFO
//   cycle_count, store_count     : saturating run counters
//   done, timeout, overflow      : sticky status flags
// ---------------------------------------------------------------------------
module store_monitor
    import monitor_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] HALT_ADDR  = DEFAULT_HALT_ADDR,
    parameter int          MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        rd_en,
    output logic        rd_valid,
    output logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic [31:0] cycle_count,
    output logic [31:0] store_count,
    output logic        done,
    output logic        timeout,
    output logic        overflow
);

    localparam logic [31:0] MAX_CYCLES_W = 32'(MAX_CYCLES);

    state_e       state_q, state_d;
    logic [31:0]  cycle_q, cycle_d;
    logic [31:0]  store_q, store_d;
    logic         done_q, done_d;
    logic         timeout_q, timeout_d;
    logic         overflow_q, overflow_d;

    logic         push;
    logic         fifo_full;
    logic         fifo_empty;
    trace_entry_t push_entry;
    trace_entry_t head_entry;

    // Stores are only captured while the run is live; terminal states ignore
    // the bus but still let the FIFO drain.
    assign push       = (state_q == ST_RUN) && MemWrite;
    assign push_entry = '{addr: DataAdr, data: WriteData};

    trace_fifo #(
        .WIDTH ($bits(trace_entry_t)),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (rd_en),
        .head_o      (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // NOTE: every next-state signal gets its default first so no path through
    // the block leaves a variable unassigned (which would infer a latch).
    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        store_d    = store_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;

        if (state_q == ST_RUN) begin
            cycle_d = sat_inc(cycle_q);

            if (MemWrite) begin
                store_d = sat_inc(store_q);
                // Full implies non-empty, so any rd_en frees a slot this edge.
                if (fifo_full && !rd_en) begin
                    overflow_d = 1'b1;
                end
            end

            // Halt takes priority over the budget expiring on the same edge.
            if (MemWrite && (DataAdr == HALT_ADDR)) begin
                state_d = ST_HALTED;
                done_d  = 1'b1;
            end else if (cycle_d == MAX_CYCLES_W) begin
                state_d   = ST_TIMEOUT;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cycle_q    <= '0;
            store_q    <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            store_q    <= store_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_valid    = !fifo_empty;
    assign rd_addr     = head_entry.addr;
    assign rd_data     = head_entry.data;
    assign cycle_count = cycle_q;
    assign store_count = store_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/store_monitor.md
# store_monitor

Synthesizable run monitor that sits directly downstream of the pipeline `top` data-memory port. It observes `MemWrite`/`DataAdr`/`WriteData` every cycle and records each store into a small show-ahead trace FIFO. It also counts run cycles and stores, and ends the run either on a store to a halt address (`done`) or on a cycle budget (`timeout`). It gives the bench and FPGA builds one place to read results instead of ad-hoc `$display` polling.

## Interface
Parameters:
- `DEPTH`, 8 — trace FIFO entries; power of two, ≥2.
- `HALT_ADDR`, 32'h0000_0064 — a store to this address ends the run.
- `MAX_CYCLES`, 500 — run-cycle budget before timeout; ≥1.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `MemWrite`  in  1  — store strobe from `top`.
- `DataAdr`  in  32  — store address from `top`.
- `WriteData`  in  32  — store data from `top`.
- `rd_en`  in  1  — pop request for the trace FIFO.
- `rd_valid`  out  1  — FIFO non-empty; head entry is valid.
- `rd_addr`  out  32  — head entry address.
- `rd_data`  out  32  — head entry data.
- `cycle_count`  out  32  — run cycles elapsed.
- `store_count`  out  32  — stores observed during RUN, including dropped ones.
- `done`  out  1  — halted by a store to `HALT_ADDR`; sticky.
- `timeout`  out  1  — cycle budget exhausted; sticky.
- `overflow`  out  1  — at least one store was dropped because the FIFO was full; sticky.

## Operation
- States: RUN, HALTED, TIMEOUT. Reset enters RUN. Reset values:
  - all outputs 0;
  - FIFO empty;
  - pointers 0.
- RUN:
  - `cycle_count` increments every cycle.
  - If `MemWrite`=1: push {`DataAdr`,`WriteData`} and increment `store_count`.
  - If `MemWrite`=1 and `DataAdr`==`HALT_ADDR`: push the store, go to HALTED, set `done`.
  - Else if the incremented `cycle_count`==`MAX_CYCLES`: go to TIMEOUT, set `timeout`.
  - If both conditions occur in the same cycle, halt wins.
- HALTED/TIMEOUT are terminal until reset:
  - counters freeze;
  - `MemWrite` is ignored;
  - the FIFO still drains via `rd_en`.
- FIFO behaviour:
  - Show-ahead: `rd_valid`=!empty, and `rd_addr`/`rd_data` present the head entry combinationally from storage.
  - A pop occurs when `rd_en` && `rd_valid`. `rd_en` while empty is ignored.
  - Push when full without a same-cycle pop: the entry is dropped, `overflow` is set, and `store_count` still increments.
  - Push and pop in the same cycle while full: both succeed and occupancy is unchanged.
  - Push and pop in the same cycle while empty: the push lands and no pop occurs.
- Pointers are log2(`DEPTH`) bits plus one wrap bit. Full/empty is decided by comparing the wrap bits.
- Counters are 32-bit and saturate at 32'hFFFF_FFFF; they never wrap.
- Reset asserted mid-run:
  - the FIFO is flushed;
  - all counters and sticky flags clear;
  - the state returns to RUN on the next edge.

## Timing
- Capture latency is 1 cycle: a store sampled at edge N is visible on `rd_*` after edge N (same cycle as the FIFO update).
- `done`/`timeout` assert on the edge that samples the terminating event.
- The first RUN cycle after reset deassertion yields `cycle_count`=1 after its edge.
- A pop takes effect at the edge; the next entry appears immediately after that edge.
- Sustained throughput: one push and one pop per cycle.

## Structure
- Shared package `monitor_pkg`:
  - state enum (RUN/HALTED/TIMEOUT);
  - default `HALT_ADDR` and `MAX_CYCLES` constants;
  - trace entry struct {addr[31:0], data[31:0]}.
- One sub-module: `trace_fifo`, a generic synchronous show-ahead FIFO parameterized by `WIDTH`/`DEPTH` with push/pop/full/empty. `store_monitor` holds the FSM, counters and sticky flags.

## Test plan
- Reset for 2 cycles, then 3 stores (0x10/0x1, 0x14/0x2, 0x18/0x3) with no pops → `store_count`=3, `rd_valid`=1, head=0x10/0x1; three pops return entries in order, then `rd_valid`=0.
- Store 0x64/0xAB at cycle 7 → `done`=1 after that edge; the entry is in the FIFO; a later store to 0x20 is not captured; `cycle_count` stays 7.
- `MAX_CYCLES`=20 with no halt → `timeout`=1 after edge 20; `cycle_count` holds at 20.
- `DEPTH`=4, 6 stores with no pops → `overflow`=1, `store_count`=6, FIFO holds the first 4; then push with a same-cycle pop while full → occupancy stays 4 and the newest entry is at the tail.
- With `MAX_CYCLES`=10, a halt store lands on cycle 10 → `done`=1, `timeout`=0.
- Assert `reset` mid-run with 3 entries queued → next cycle shows all outputs 0 and `rd_valid`=0; the following store is captured normally.
